// File: rtl/beta_imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package beta_imem_pkg;

  localparam int IMEM_XLEN = 32;

  typedef struct packed {
    logic                 err;
    logic [IMEM_XLEN-1:0] rdata;
  } imem_resp_t;

  typedef enum logic {
    WS_WAIT,
    WS_READY
  } imem_ws_state_e;

  // Fault on a misaligned address or a word index beyond the backing SRAM.
  function automatic logic imem_access_fault(input logic [IMEM_XLEN-1:0] addr,
                                             input int unsigned mem_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[IMEM_XLEN-1:2]} >= mem_words);
  endfunction

endpackage

// File: rtl/beta_resp_fifo.sv
// Small synchronous FIFO with a combinational head view; pointers wrap at DEPTH.
module beta_resp_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [7:0],
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  T              mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the push would otherwise find occupied.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/beta_imem_responder.sv
// OBI-style fetch responder: wait-state gated grants, 1-cycle SRAM read, in-order response buffer.
module beta_imem_responder
  import beta_imem_pkg::*;
#(
  parameter int  XLEN            = IMEM_XLEN,
  parameter int  MEM_WORDS       = 1024,
  parameter int  MAX_OUTSTANDING = 2,
  parameter int  WAIT_STATES     = 0,
  localparam int AW              = $clog2(MEM_WORDS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [XLEN-1:0] addr_i,
  output logic            gnt_o,
  output logic            rvalid_o,
  input  logic            rready_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o,
  output logic            mem_req_o,
  output logic [AW-1:0]   mem_addr_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam imem_ws_state_e WS_IDLE = (WAIT_STATES == 0) ? WS_READY : WS_WAIT;

  imem_ws_state_e ws_state_reg, ws_state_next;
  logic [3:0]     wcnt_reg, wcnt_next;
  logic           pipe_valid_reg;
  logic           pipe_err_reg;

  logic           fault;
  logic           credit;
  logic [CW:0]    occ;
  imem_resp_t     push_entry;
  imem_resp_t     head_entry;
  logic           fifo_empty;
  logic           fifo_full;
  logic [CW-1:0]  fifo_count;
  logic           pop;

  // Credit uses registered occupancy only; a same-cycle pop never frees a slot early.
  always_comb begin
    occ        = {1'b0, fifo_count} + (CW + 1)'(pipe_valid_reg);
    credit     = occ < (CW + 1)'(MAX_OUTSTANDING);
    fault      = imem_access_fault(addr_i, int'(MEM_WORDS));
    gnt_o      = req_i & ~rst_i & (ws_state_reg == WS_READY) & credit;
    mem_req_o  = gnt_o & ~fault;
    mem_addr_o = mem_req_o ? addr_i[2 +: AW] : '0;
  end

  always_comb begin
    wcnt_next     = wcnt_reg;
    ws_state_next = ws_state_reg;
    if (gnt_o || !req_i) begin
      wcnt_next     = '0;
      ws_state_next = WS_IDLE;
    end else if (ws_state_reg == WS_WAIT) begin
      if (wcnt_reg < 4'(WAIT_STATES)) wcnt_next = wcnt_reg + 1'b1;
      if (wcnt_next == 4'(WAIT_STATES)) ws_state_next = WS_READY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ws_state_reg   <= WS_IDLE;
      wcnt_reg       <= '0;
      pipe_valid_reg <= 1'b0;
      pipe_err_reg   <= 1'b0;
    end else begin
      ws_state_reg   <= ws_state_next;
      wcnt_reg       <= wcnt_next;
      pipe_valid_reg <= gnt_o;
      pipe_err_reg   <= fault;
    end
  end

  // SRAM data arrives in the cycle after the grant and is merged straight into the push.
  always_comb begin
    push_entry.err   = pipe_err_reg;
    push_entry.rdata = pipe_err_reg ? '0 : mem_rdata_i;
  end

  beta_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (imem_resp_t)
  ) u_resp_fifo (
    .clk       (clk_i),
    .srst      (rst_i),
    .push      (pipe_valid_reg),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign rvalid_o = ~fifo_empty;
  assign pop      = rvalid_o & rready_i;
  assign rdata_o  = rvalid_o ? head_entry.rdata : '0;
  assign err_o    = rvalid_o & head_entry.err;

  a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (req_i && !gnt_o) |=> (!req_i || $stable(addr_i)));
  a_rvalid_nonempty: assert property (@(posedge clk_i) disable iff (rst_i)
    rvalid_o |-> (fifo_count != '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(fifo_full && pipe_valid_reg && !pop));

endmodule

// File: tb/tb_beta_imem_responder.sv
// Two responder instances (no wait states / depth 2, three wait states / depth 3) checked per cycle against a transaction model.
module tb_beta_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req      [2];
  logic [31:0] addr     [2];
  logic        rready   [2];
  logic        gnt      [2];
  logic        rvalid   [2];
  logic [31:0] rdata    [2];
  logic        err      [2];
  logic        mem_req  [2];
  logic [9:0]  mem_addr [2];
  logic [31:0] mem_rdata[2];

  logic [31:0] sram [1024];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: per instance, a queue of granted responses with their grant cycle.
  int          held  [2];
  int          qhead [2];
  int          qtail [2];
  int          pops  [2];
  logic        m_err [2][16];
  logic [31:0] m_data[2][16];
  int          m_gc  [2][16];

  always #5 clk = ~clk;

  beta_imem_responder #(.XLEN(32), .MEM_WORDS(1024), .MAX_OUTSTANDING(2), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .addr_i(addr[0]), .gnt_o(gnt[0]),
    .rvalid_o(rvalid[0]), .rready_i(rready[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .mem_req_o(mem_req[0]), .mem_addr_o(mem_addr[0]), .mem_rdata_i(mem_rdata[0]));

  beta_imem_responder #(.XLEN(32), .MEM_WORDS(1024), .MAX_OUTSTANDING(3), .WAIT_STATES(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .addr_i(addr[1]), .gnt_o(gnt[1]),
    .rvalid_o(rvalid[1]), .rready_i(rready[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .mem_req_o(mem_req[1]), .mem_addr_o(mem_addr[1]), .mem_rdata_i(mem_rdata[1]));

  // SRAM model: 1-cycle read latency, garbage on idle cycles.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      mem_rdata[d] <= mem_req[d] ? sram[mem_addr[d]] : $urandom;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int d);
    int   ws, mo, c;
    logic f, eg, erv;
    ws  = (d == 0) ? 0 : 3;
    mo  = (d == 0) ? 2 : 3;
    f   = (addr[d][1:0] != 2'b00) || ((addr[d] >> 2) >= 32'd1024);
    c   = qtail[d] - qhead[d];
    eg  = !rst && req[d] && (held[d] >= ws) && (c < mo);
    erv = (c > 0) && (m_gc[d][qhead[d] % 16] <= cyc - 2);
    chk($sformatf("d%0d_gnt", d), 32'(gnt[d]), 32'(eg));
    chk($sformatf("d%0d_mem_req", d), 32'(mem_req[d]), 32'(eg && !f));
    if (eg && !f) chk($sformatf("d%0d_mem_addr", d), 32'(mem_addr[d]), 32'(addr[d][11:2]));
    chk($sformatf("d%0d_rvalid", d), 32'(rvalid[d]), 32'(erv));
    if (erv) begin
      chk($sformatf("d%0d_rdata", d), rdata[d], m_data[d][qhead[d] % 16]);
      chk($sformatf("d%0d_err", d), 32'(err[d]), 32'(m_err[d][qhead[d] % 16]));
    end
    if (rst) begin
      qhead[d] = 0;
      qtail[d] = 0;
      held[d]  = 0;
    end else begin
      if (rvalid[d] && rready[d]) begin
        $display("[TB] dut%0d cyc %0d response err=%0d data=%08h", d, cyc, err[d], rdata[d]);
        if (c > 0) qhead[d]++;
        pops[d]++;
      end
      if (eg) begin
        m_err[d][qtail[d] % 16]  = f;
        m_data[d][qtail[d] % 16] = f ? 32'h0 : sram[addr[d][11:2]];
        m_gc[d][qtail[d] % 16]   = cyc;
        qtail[d]++;
      end
      held[d] = (eg || !req[d]) ? 0 : held[d] + 1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    mon(0);
    mon(1);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return {20'h0, 10'($urandom_range(0, 1023)), 2'b10};
    if (r == 1) return 32'd4096 + {$urandom_range(0, 255), 2'b00};
    return {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
  endfunction

  task automatic drain();
    rready[0] = 1'b1;
    rready[1] = 1'b1;
    for (int t = 0; t < 20 && (qtail[0] != qhead[0] || qtail[1] != qhead[1]); t++) step();
    chk("drain_d0", 32'(qtail[0] - qhead[0]), 32'd0);
    chk("drain_d1", 32'(qtail[1] - qhead[1]), 32'd0);
  endtask

  initial begin
    logic [31:0] fault_addrs [2];
    int          g_cnt [2];
    logic        g_seen[2];
    int          pops0 [2];

    for (int i = 0; i < 1024; i++) sram[i] = $urandom;
    sram[5] = 32'h00500093;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; addr[d] = 32'h0; rready[d] = 1'b1;
      held[d] = 0; qhead[d] = 0; qtail[d] = 0; pops[d] = 0;
    end

    // Reset
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    sample();
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt", 32'(gnt[d]), 0);
      chk("rst_rvalid", 32'(rvalid[d]), 0);
      chk("rst_rdata", rdata[d], 0);
      chk("rst_err", 32'(err[d]), 0);
      chk("rst_mem_req", 32'(mem_req[d]), 0);
      chk("rst_mem_addr", 32'(mem_addr[d]), 0);
    end
    advance();

    // Zero wait states: same-cycle grant, response two cycles later
    req[0] = 1'b1; addr[0] = 32'h14;
    sample();
    chk("ws0_gnt", 32'(gnt[0]), 1);
    chk("ws0_mem_addr", 32'(mem_addr[0]), 5);
    advance();
    req[0] = 1'b0;
    sample();
    chk("ws0_rvalid_early", 32'(rvalid[0]), 0);
    advance();
    sample();
    chk("ws0_rvalid", 32'(rvalid[0]), 1);
    chk("ws0_rdata", rdata[0], 32'h00500093);
    chk("ws0_err", 32'(err[0]), 0);
    advance();

    // Three wait states, then a dropped request restarting the count
    req[1] = 1'b1; addr[1] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      sample(); chk($sformatf("ws3_gnt_k%0d", k), 32'(gnt[1]), 32'(k == 3)); advance();
    end
    req[1] = 1'b0;
    step();
    req[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sample(); chk("ws3_partial_gnt", 32'(gnt[1]), 0); advance();
    end
    req[1] = 1'b0;
    step();
    req[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample(); chk($sformatf("ws3_restart_k%0d", k), 32'(gnt[1]), 32'(k == 3)); advance();
    end
    req[1] = 1'b0;
    drain();

    // Access faults
    fault_addrs[0] = 32'h6;
    fault_addrs[1] = 32'd4096;
    for (int i = 0; i < 2; i++) begin
      req[0] = 1'b1; addr[0] = fault_addrs[i];
      sample();
      chk("fault_gnt", 32'(gnt[0]), 1);
      chk("fault_mem_req", 32'(mem_req[0]), 0);
      advance();
      req[0] = 1'b0;
      step();
      sample();
      chk("fault_rvalid", 32'(rvalid[0]), 1);
      chk("fault_err", 32'(err[0]), 1);
      chk("fault_rdata", rdata[0], 0);
      advance();
    end

    // Credit limit with two outstanding
    rready[0] = 1'b0;
    req[0] = 1'b1; addr[0] = 32'h0;
    sample(); chk("cred_gnt_a", 32'(gnt[0]), 1); advance();
    addr[0] = 32'h4;
    sample(); chk("cred_gnt_b", 32'(gnt[0]), 1); advance();
    addr[0] = 32'h8;
    for (int k = 0; k < 3; k++) begin
      sample(); chk("cred_gnt_c_blocked", 32'(gnt[0]), 0); advance();
    end
    rready[0] = 1'b1;
    sample();
    chk("cred_gnt_c_same_pop", 32'(gnt[0]), 0);
    chk("cred_head_a", rdata[0], sram[0]);
    advance();
    sample();
    chk("cred_gnt_c", 32'(gnt[0]), 1);
    chk("cred_head_b", rdata[0], sram[1]);
    advance();
    req[0] = 1'b0;
    drain();

    // Random burst of 8 requests per instance with random backpressure
    for (int d = 0; d < 2; d++) begin g_cnt[d] = 0; pops0[d] = pops[d]; end
    for (int t = 0; t < 600 && (g_cnt[0] < 8 || g_cnt[1] < 8); t++) begin
      for (int d = 0; d < 2; d++) begin
        rready[d] = 1'($urandom_range(0, 1));
        if (!req[d] && g_cnt[d] < 8) begin
          req[d]  = 1'b1;
          addr[d] = rand_addr();
        end
      end
      sample();
      for (int d = 0; d < 2; d++) g_seen[d] = gnt[d];
      advance();
      for (int d = 0; d < 2; d++) if (g_seen[d]) begin g_cnt[d]++; req[d] = 1'b0; end
    end
    chk("burst_grants_d0", 32'(g_cnt[0]), 8);
    chk("burst_grants_d1", 32'(g_cnt[1]), 8);
    drain();
    chk("burst_pops_d0", 32'(pops[0] - pops0[0]), 8);
    chk("burst_pops_d1", 32'(pops[1] - pops0[1]), 8);

    // Reset with two responses outstanding
    rready[0] = 1'b0;
    req[0] = 1'b1; addr[0] = 32'h20;
    step();
    addr[0] = 32'h24;
    step();
    req[0] = 1'b0;
    step();
    sample(); chk("prerst_rvalid", 32'(rvalid[0]), 1); advance();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    chk("midrst_rvalid", 32'(rvalid[0]), 0);
    chk("midrst_rdata", rdata[0], 0);
    chk("midrst_err", 32'(err[0]), 0);
    chk("midrst_gnt", 32'(gnt[0]), 0);
    chk("midrst_mem_req", 32'(mem_req[0]), 0);
    advance();
    rready[0] = 1'b1;
    repeat (3) step();
    req[0] = 1'b1; addr[0] = 32'h14;
    sample(); chk("postrst_gnt", 32'(gnt[0]), 1); advance();
    req[0] = 1'b0;
    step();
    sample();
    chk("postrst_rvalid", 32'(rvalid[0]), 1);
    chk("postrst_rdata", rdata[0], 32'h00500093);
    advance();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
